// File: rtl/status_text_writer.sv
// Renders live ride status into the character RAM: clears it to spaces after reset,
// then periodically (or on request) writes speed and trip distance as blank-suppressed ASCII.
module status_text_writer #(
   parameter int          COLS           = 40,
   parameter logic [9:0]  SPD_ADDR       = 10'd0,
   parameter logic [9:0]  DST_ADDR       = 10'(COLS),
   parameter logic [23:0] REFRESH_CYCLES = 24'd5_000_000,
   parameter int          RAM_DEPTH      = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  speed,
   input  logic [15:0] distance,
   input  logic        update,
   output logic        ram_we,
   output logic [9:0]  ram_addr,
   output logic [6:0]  ram_data,
   output logic        busy
);

   localparam logic [9:0] LAST_ADDR = 10'(RAM_DEPTH - 1);
   localparam logic [6:0] SPACE     = 7'h20;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_LATCH,
      S_CONV_SPD,
      S_WR_SPD,
      S_CONV_DST,
      S_WR_DST
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  clr_q, clr_d;
   logic [23:0] timer_q, timer_d;
   logic        pending_q, pending_d;
   logic [15:0] bin_q, bin_d;
   logic [15:0] dst_snap_q, dst_snap_d;
   logic [19:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        nz_q, nz_d;
   logic        ram_we_q, ram_we_d;
   logic [9:0]  ram_addr_q, ram_addr_d;
   logic [6:0]  ram_data_q, ram_data_d;
   logic        busy_q, busy_d;

   logic [35:0] dd;
   logic [2:0]  msd_idx;
   logic [2:0]  idx;
   logic [3:0]  digit;
   logic        field_last;
   logic        blank;
   logic [9:0]  field_base;

   // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift {bcd, bin} left.
   function automatic logic [35:0] dd_step(input logic [19:0] bcd, input logic [15:0] bin);
      logic [19:0] adj;
      for (int i = 0; i < 5; i++) begin
         adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
      return {adj[18:0], bin, 1'b0};
   endfunction

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      clr_d      = clr_q;
      timer_d    = timer_q;
      pending_d  = pending_q;
      bin_d      = bin_q;
      dst_snap_d = dst_snap_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      nz_d       = nz_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      busy_d     = (state_q != S_IDLE);

      dd         = dd_step(bcd_q, bin_q);
      msd_idx    = (state_q == S_WR_SPD) ? 3'd2 : 3'd4;
      idx        = msd_idx - cnt_q[2:0];
      digit      = 4'(bcd_q >> {idx, 2'b00});
      field_last = (cnt_q[2:0] == msd_idx);
      blank      = (digit == 4'd0) && !nz_q && !field_last;
      field_base = (state_q == S_WR_SPD) ? SPD_ADDR : DST_ADDR;

      if (update && (state_q != S_IDLE)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         S_CLEAR: begin
            ram_we_d   = 1'b1;
            ram_addr_d = clr_q;
            ram_data_d = SPACE;
            clr_d      = clr_q + 10'd1;
            if (clr_q == LAST_ADDR) begin
               state_d = S_LATCH;
            end
         end
         S_IDLE: begin
            if ((timer_q == REFRESH_CYCLES - 24'd1) || update || pending_q) begin
               timer_d   = '0;
               pending_d = 1'b0;
               state_d   = S_LATCH;
            end else begin
               timer_d = timer_q + 24'd1;
            end
         end
         S_LATCH: begin
            bin_d      = {speed, 8'h00};
            dst_snap_d = distance;
            bcd_d      = '0;
            cnt_d      = '0;
            nz_d       = 1'b0;
            state_d    = S_CONV_SPD;
         end
         S_CONV_SPD, S_CONV_DST: begin
            bcd_d = dd[35:16];
            bin_d = dd[15:0];
            cnt_d = cnt_q + 4'd1;
            if (((state_q == S_CONV_SPD) && (cnt_q == 4'd7)) ||
                ((state_q == S_CONV_DST) && (cnt_q == 4'd15))) begin
               cnt_d   = '0;
               nz_d    = 1'b0;
               state_d = (state_q == S_CONV_SPD) ? S_WR_SPD : S_WR_DST;
            end
         end
         S_WR_SPD, S_WR_DST: begin
            ram_we_d   = 1'b1;
            ram_addr_d = field_base + 10'(cnt_q);
            ram_data_d = blank ? SPACE : {3'b011, digit};
            nz_d       = nz_q | (digit != 4'd0);
            cnt_d      = cnt_q + 4'd1;
            if (field_last) begin
               cnt_d = '0;
               if (state_q == S_WR_SPD) begin
                  bin_d   = dst_snap_q;
                  bcd_d   = '0;
                  state_d = S_CONV_DST;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_CLEAR;
         clr_q      <= '0;
         timer_q    <= '0;
         pending_q  <= 1'b0;
         bin_q      <= '0;
         dst_snap_q <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         nz_q       <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_q      <= clr_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         bin_q      <= bin_d;
         dst_snap_q <= dst_snap_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         nz_q       <= nz_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         busy_q     <= busy_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_status_text_writer.sv
// Bench for status_text_writer: directed and random refreshes checked against a
// decimal-formatting model, plus pending, timer, coincidence and reset-abort scenarios.
module tb_status_text_writer;

   localparam logic [9:0] SPD_ADDR = 10'd0;
   localparam logic [9:0] DST_ADDR = 10'd40;
   localparam int         RC       = 64;
   localparam int         DEPTH    = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  speed = '0;
   logic [15:0] distance = '0;
   logic        update = 1'b0;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [6:0]  ram_data;
   logic        busy;

   status_text_writer #(
      .COLS(40), .SPD_ADDR(SPD_ADDR), .DST_ADDR(DST_ADDR),
      .REFRESH_CYCLES(24'(RC)), .RAM_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .speed(speed), .distance(distance), .update(update),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [9:0] a;
      logic [6:0] d;
      int         c;
   } wr_t;

   wr_t wq[$];
   wr_t mon_w;

   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         mon_w.a = ram_addr;
         mon_w.d = ram_data;
         mon_w.c = cyc;
         wq.push_back(mon_w);
      end
   end

   int checks = 0;
   int errors = 0;
   int offs[8] = '{0, 1, 2, 19, 20, 21, 22, 23};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Decimal digit of weight 10**p, or a space when it is a leading zero.
   function automatic logic [6:0] exp_char(input int v, input int p);
      int pw = 1;
      for (int i = 0; i < p; i++) pw *= 10;
      if (p > 0 && v < pw) return 7'h20;
      return 7'(48 + (v / pw) % 10);
   endfunction

   function automatic logic [9:0] exp_addr(input int k);
      if (k < 3) return 10'((int'(SPD_ADDR) + k) % DEPTH);
      return 10'((int'(DST_ADDR) + k - 3) % DEPTH);
   endfunction

   function automatic logic [6:0] exp_data(input int s, input int d, input int k);
      if (k < 3) return exp_char(s, 2 - k);
      return exp_char(d, 7 - k);
   endfunction

   task automatic wait_writes(input int n, input int budget, input string tag);
      int waited = 0;
      while (wq.size() < n && waited < budget) begin
         step();
         waited++;
      end
      check({tag, "_arrived"}, 32'(wq.size() >= n), 32'd1);
   endtask

   task automatic pulse_update(output int c);
      update = 1'b1;
      c = cyc;
      step();
      update = 1'b0;
   endtask

   task automatic expect_clear(input int r, input string tag);
      wr_t w;
      int  bad = 0;
      wait_writes(DEPTH, DEPTH + 50, tag);
      if (wq.size() < DEPTH) return;
      for (int i = 0; i < DEPTH; i++) begin
         w = wq.pop_front();
         if (w.a !== 10'(i) || w.d !== 7'h20 || w.c !== r + 1 + i) bad++;
      end
      check({tag, "_bad_writes"}, 32'(bad), 32'd0);
   endtask

   task automatic expect_refresh(input int s, input int d, input string tag,
                                 input int exp_first, output int first);
      wr_t w;
      int  last = 0;
      int  waited = 0;
      first = -1;
      wait_writes(8, 200, tag);
      if (wq.size() < 8) return;
      for (int k = 0; k < 8; k++) begin
         w = wq.pop_front();
         if (k == 0) begin
            first = w.c;
            check({tag, "_start"}, 32'(w.c), 32'(exp_first));
         end
         check($sformatf("%s_addr%0d", tag, k), 32'(w.a), 32'(exp_addr(k)));
         check($sformatf("%s_data%0d", tag, k), 32'(w.d), 32'(exp_data(s, d, k)));
         check($sformatf("%s_cyc%0d", tag, k), 32'(w.c - first), 32'(offs[k]));
         last = w.c;
      end
      while (busy === 1'b1 && waited < 50) begin
         step();
         waited++;
      end
      check({tag, "_busy_fall"}, 32'(cyc), 32'(last + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, c, f0, f1, f2, f3, f4, fa, fb;
      int s0, d0, s1, d1, s2, d2, s3, d3;
      int lim_s[3] = '{9, 99, 255};
      int lim_d[5] = '{9, 99, 999, 9999, 65535};
      int dir_s[4] = '{205, 255, 10, 0};
      int dir_d[4] = '{7, 65535, 1000, 0};

      // Reset state
      #1 rst = 1'b0;
      step(); step(); step();
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      check("rst_data", 32'(ram_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Release: full clear, then a forced refresh of zero inputs
      rst = 1'b1;
      r = cyc;
      expect_clear(r, "clear");
      expect_refresh(0, 0, "init", r + 1034, f0);

      // Directed patterns then random ones, each triggered by update
      for (int i = 0; i < 4; i++) begin
         speed = 8'(dir_s[i]);
         distance = 16'(dir_d[i]);
         pulse_update(c);
         expect_refresh(dir_s[i], dir_d[i], $sformatf("dir%0d", i), c + 11, f0);
      end
      for (int i = 0; i < 8; i++) begin
         s0 = int'($urandom_range(0, lim_s[i % 3]));
         d0 = int'($urandom_range(0, lim_d[i % 5]));
         speed = 8'(s0);
         distance = 16'(d0);
         pulse_update(c);
         expect_refresh(s0, d0, $sformatf("rnd%0d", i), c + 11, f0);
      end

      // Requests while busy collapse to one; inputs changed after latch are not shown
      s0 = int'($urandom_range(0, 255));
      d0 = int'($urandom_range(0, 65535));
      s1 = (s0 + 77) % 256;
      d1 = (d0 + 12345) % 65536;
      speed = 8'(s0);
      distance = 16'(d0);
      pulse_update(c);
      step(); step(); step();
      speed = 8'(s1);
      distance = 16'(d1);
      for (int i = 0; i < 3; i++) begin
         update = 1'b1;
         step();
         update = 1'b0;
         step();
      end
      expect_refresh(s0, d0, "latched", c + 11, f0);
      expect_refresh(s1, d1, "pending", f0 + 34, f1);
      expect_refresh(s1, d1, "auto", f1 + RC + 33, f2);

      // update coincident with timer expiry yields a single refresh
      s2 = int'($urandom_range(0, 255));
      d2 = int'($urandom_range(0, 65535));
      speed = 8'(s2);
      distance = 16'(d2);
      while (cyc < f2 + RC + 22) step();
      update = 1'b1;
      step();
      update = 1'b0;
      expect_refresh(s2, d2, "coincide", f2 + RC + 33, f3);
      expect_refresh(s2, d2, "after_coincide", f3 + RC + 33, f4);

      // Reset during distance writes aborts at once and restarts with a clear
      s3 = int'($urandom_range(1, 255));
      d3 = int'($urandom_range(10000, 65535));
      speed = 8'(s3);
      distance = 16'(d3);
      pulse_update(c);
      wait_writes(4, 60, "abort");
      rst = 1'b0;
      #1;
      check("abort_we", 32'(ram_we), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_addr", 32'(ram_addr), 32'd0);
      wq.delete();
      step(); step();
      check("abort_held_we", 32'(ram_we), 32'd0);
      rst = 1'b1;
      r = cyc;
      step(); step(); step();
      pulse_update(c);
      expect_clear(r, "reclear");
      expect_refresh(s3, d3, "post_reset", r + 1034, fa);
      expect_refresh(s3, d3, "clear_pending", fa + 34, fb);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
